// File: rtl/mul_rr_scheduler.sv
// Round-robin scheduler sharing one sequential radix-2 Booth signed multiplier between two
// requesters. A product is presented with its requester ID on a valid/ready response port.
module mul_rr_scheduler #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic               busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q1_q, q1_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             id_q, id_d;

  logic             grant0, grant1;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sel_a, sel_b;

  // Pointer selects the winner only when both requesters are valid.
  assign grant0 = req0_valid & (~req1_valid | ~ptr_q);
  assign grant1 = req1_valid & (~req0_valid | ptr_q);

  assign sel_a = grant1 ? req1_a : req0_a;
  assign sel_b = grant1 ? req1_b : req0_b;

  // Gated with rst_n so both readies read 0 while reset is held.
  assign req0_ready = rst_n & (state_q == StIdle) & grant0;
  assign req1_ready = rst_n & (state_q == StIdle) & grant1;

  assign rsp_valid  = (state_q == StDone);
  assign rsp_id     = id_q;
  assign rsp_result = {acc_q[WIDTH-1:0], q_q};
  assign busy       = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    sum     = acc_q;

    unique case (state_q)
      StIdle: begin
        if (grant0 | grant1) begin
          m_d     = {sel_a[WIDTH-1], sel_a};
          q_d     = sel_b;
          acc_d   = '0;
          q1_d    = 1'b0;
          cnt_d   = CntW'(WIDTH);
          id_d    = grant1;
          state_d = StRun;
        end
      end
      StRun: begin
        unique case ({q_q[0], q1_q})
          2'b10:   sum = acc_q - m_q;
          2'b01:   sum = acc_q + m_q;
          default: sum = acc_q;
        endcase
        // Arithmetic shift right of {acc, q, q_1}.
        acc_d = {sum[WIDTH], sum[WIDTH:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (rsp_ready) begin
          state_d = StIdle;
          ptr_d   = ~id_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
    end
  end

endmodule

// File: doc/mul_rr_scheduler.md
Name: mul_rr_scheduler

Overview:
- Shares one sequential radix-2 Booth signed multiplier engine between two requesters in the calculator datapath.
- Arbitrates round-robin and captures the winner's operands with a valid/ready handshake.
- Sequences WIDTH Booth add/sub-and-shift steps, then presents the 2*WIDTH-bit signed product and the requester ID on a valid/ready response port.
- Sits between the operand/keypad front end and the result display/mux logic.

Parameters:
- WIDTH, 8, signed operand width in bits; product width is 2*WIDTH.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req0_valid  in  1  requester 0 has operands.
- req0_ready  out  1  scheduler accepts requester 0 this cycle.
- req0_a  in  WIDTH  requester 0 multiplicand, two's complement.
- req0_b  in  WIDTH  requester 0 multiplier, two's complement.
- req1_valid  in  1  requester 1 has operands.
- req1_ready  out  1  scheduler accepts requester 1 this cycle.
- req1_a  in  WIDTH  requester 1 multiplicand.
- req1_b  in  WIDTH  requester 1 multiplier.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer takes product.
- rsp_id  out  1  requester the product belongs to.
- rsp_result  out  2*WIDTH  signed product.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, asynchronous):
  - state goes to IDLE; rsp_valid, req0_ready, req1_ready and busy are 0.
  - rsp_id is 0 and rsp_result is 0; step count is 0.
  - Round-robin pointer favours requester 0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - Grant is combinational from the valids. Only one valid: grant it. Both valid: grant the pointer side.
  - reqN_ready = (state==IDLE) & grantN. Ready therefore depends combinationally on valid.
  - On a handshake (valid & ready) at the rising edge:
    - m <- a; q <- b; acc <- 0; q_1 <- 0; count <- WIDTH; id <- grantee.
    - state goes to RUN.
  - Requesters hold valid and operands stable until ready. Once asserted, valid may not be withdrawn before acceptance.
- RUN, one Booth step per cycle:
  - {q[0],q_1}=10: acc <- acc - m. {q[0],q_1}=01: acc <- acc + m. 00 or 11: no change.
  - Then arithmetic shift right of {acc,q,q_1} by 1, replicating the acc sign bit. count decrements.
  - After the step with count==1, state goes to DONE.
- Accumulator width:
  - acc is WIDTH+1 bits with m sign-extended, so -2^(WIDTH-1) operands never overflow.
  - rsp_result = {acc[WIDTH-1:0], q}. This is exact for all operand pairs.
- Latency:
  - Accept edge E0; steps at E1..E_WIDTH; rsp_valid high after edge E_WIDTH.
  - That is 8 cycles for WIDTH=8. Latency is independent of operand values.
- DONE:
  - rsp_valid=1. rsp_result and rsp_id stay stable until rsp_ready.
  - On rsp_valid & rsp_ready: state goes to IDLE, and the pointer is set to favour the requester not just served.
  - No request is accepted in DONE. The earliest next accept is the cycle after the response handshake, giving throughput of 1 product per WIDTH+2 cycles minimum.
- rsp_result outside DONE: it tracks the internal registers and is don't-care; consumers qualify it with rsp_valid.
- rsp_ready while not in DONE is ignored.
- Reset mid-operation (RUN or DONE): the job is abandoned, no response is issued, and the pointer returns to requester 0.

Test Plan:
1. Reset check: assert rst_n low asynchronously mid-cycle -> all outputs 0 immediately; after release with no valids -> busy=0, both readies 0.
2. Single request: req0 a=7, b=0xFD (-3), rsp_ready=1 -> req0_ready high in the accept cycle; rsp_valid rises 8 cycles later; rsp_result=0xFFEB, rsp_id=0.
3. Signed extremes:
   - a=0x80, b=0x80 -> 0x4000.
   - a=0x7F, b=0x80 -> 0xC080.
   - a=0x80, b=0x01 -> 0xFF80.
   - a=0, b=0x55 -> 0x0000.
4. Arbitration with both valids held continuously:
   - req0 5*6, req1 -1*-1 -> grants alternate 0,1,0,1.
   - Results 0x001E (id 0) and 0x0001 (id 1).
   - No requester is starved.
5. Back-pressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_result and rsp_id stable; both readies 0; busy=1. After rsp_ready=1 -> IDLE next cycle, next grant the following cycle.
6. Reset during RUN: drop rst_n after the 4th step of req1 3*4 -> no rsp_valid. Then a new req1 4*4 -> 0x0010 with id 1, served under requester-0 priority if both valid.
